// File: rtl/seg_msg_pkg.sv
// Shared types and message content for the Battleship status scanner.
// The glyph symbols, message ids and the per-digit message table live here.
package seg_msg_pkg;

    typedef enum logic [4:0] {
        G_BLANK,
        G_P,
        G_1,
        G_2,
        G_S,
        G_E,
        G_C,
        G_A,
        G_L,
        G_N,
        G_R,
        G_U,
        G_T,
        G_APOS,
        G_H,
        G_B,
        G_I
    } glyph_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P1_PLACE = 3'd1,
        P2_PLACE = 3'd2,
        P1_FIRE  = 3'd3,
        P2_FIRE  = 3'd4
    } msg_id_t;

    localparam int unsigned MSG_DIGITS = 8;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    // Indexed [msg_id][digit]; digit 0 is the rightmost character.
    localparam glyph_t MSG_TABLE [5][MSG_DIGITS] = '{
        '{G_P, G_I, G_H, G_S, G_B, G_BLANK, G_BLANK, G_BLANK},  // "   BSHIP"
        '{G_S, G_E, G_C, G_A, G_L, G_P,     G_1,     G_P    },  // "P1PLACES"
        '{G_S, G_E, G_C, G_A, G_L, G_P,     G_2,     G_P    },  // "P2PLACES"
        '{G_N, G_R, G_U, G_T, G_S, G_APOS,  G_1,     G_P    },  // "P1'STURN"
        '{G_N, G_R, G_U, G_T, G_S, G_APOS,  G_2,     G_P    }   // "P2'STURN"
    };

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph to 7-segment cathode pattern, {dp,g,f,e,d,c,b,a} active-low.
module seg_glyph_rom
    import seg_msg_pkg::*;
(
    input  glyph_t     glyph,
    output logic [7:0] code
);

    always_comb begin
        code = GLYPH_BLANK;
        case (glyph)
            G_P:     code = 8'h8C;
            G_1:     code = 8'hF9;
            G_2:     code = 8'hA4;
            G_S:     code = 8'h92;
            G_E:     code = 8'h86;
            G_C:     code = 8'hC6;
            G_A:     code = 8'h88;
            G_L:     code = 8'hC7;
            G_N:     code = 8'hAB;
            G_R:     code = 8'hAF;
            G_U:     code = 8'hE3;
            G_T:     code = 8'h87;
            G_APOS:  code = 8'hFD;
            G_H:     code = 8'h89;
            G_B:     code = 8'h83;
            G_I:     code = 8'hF9;
            default: code = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_msg_scanner.sv
// Self-timed multiplexed 7-segment message scanner: picks a status message from the
// game-phase flags, swaps it only at frame boundaries and blinks it after each change.
module seg_msg_scanner
    import seg_msg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned BLINK_HALF   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p1_place,
    input  logic                  p2_place,
    input  logic                  p1_fire,
    input  logic                  p2_fire,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [7:0]            cathode,
    output logic                  frame_tick
);

    localparam int unsigned DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [DIG_W-1:0]      dig_idx_q, dig_idx_d;
    msg_id_t               active_msg_q, active_msg_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [7:0]            cathode_q, cathode_d;
    logic                  frame_tick_q, frame_tick_d;

    msg_id_t    req_msg;
    logic       div_last;
    logic       dig_last;
    logic       wrap;
    logic       blank;
    logic [4:0] dig_ext;
    logic [31:0] elapsed;
    glyph_t     glyph_sel;
    logic [7:0] glyph_code;

    always_comb begin
        req_msg = IDLE;
        if (p1_place) begin
            req_msg = P1_PLACE;
        end else if (p2_place) begin
            req_msg = P2_PLACE;
        end else if (p1_fire) begin
            req_msg = P1_FIRE;
        end else if (p2_fire) begin
            req_msg = P2_FIRE;
        end
    end

    always_comb begin
        div_last = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
        dig_last = (dig_idx_q == DIG_W'(NUM_DIGITS - 1));
        wrap     = div_last && dig_last;

        div_cnt_d = div_last ? '0 : div_cnt_q + DIV_W'(1);

        dig_idx_d = dig_idx_q;
        if (div_last) begin
            dig_idx_d = dig_last ? '0 : dig_idx_q + DIG_W'(1);
        end

        // Message and blink state move on the same edge that starts the new frame,
        // so every digit of that frame sees one consistent message.
        active_msg_d = active_msg_q;
        blink_cnt_d  = blink_cnt_q;
        if (wrap) begin
            active_msg_d = req_msg;
            if (req_msg != active_msg_q) begin
                blink_cnt_d = BLINK_W'(BLINK_FRAMES);
            end else if (blink_cnt_q != '0) begin
                blink_cnt_d = blink_cnt_q - BLINK_W'(1);
            end
        end

        frame_tick_d = wrap;
    end

    // Frames elapsed since the change; even half-periods are lit, odd ones dark.
    always_comb begin
        elapsed = 32'(BLINK_FRAMES) - 32'(blink_cnt_q);
        blank   = (blink_cnt_q != '0) && (((elapsed / 32'(BLINK_HALF)) % 32'd2) != 32'd0);
    end

    always_comb begin
        dig_ext   = 5'(dig_idx_q);
        glyph_sel = G_BLANK;
        if (dig_ext < 5'(MSG_DIGITS)) begin
            glyph_sel = MSG_TABLE[active_msg_q][dig_ext[2:0]];
        end
    end

    seg_glyph_rom u_glyph_rom (
        .glyph (glyph_sel),
        .code  (glyph_code)
    );

    always_comb begin
        anode_d   = ~(NUM_DIGITS'(1) << dig_idx_q);
        cathode_d = blank ? GLYPH_BLANK : glyph_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            dig_idx_q    <= '0;
            active_msg_q <= IDLE;
            blink_cnt_q  <= '0;
            anode_q      <= '1;
            cathode_q    <= GLYPH_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_idx_q    <= dig_idx_d;
            active_msg_q <= active_msg_d;
            blink_cnt_q  <= blink_cnt_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_msg_scanner.sv
// Directed bench for seg_msg_scanner: scan order, message priority, frame-aligned
// switching, blink sequence, short-pulse rejection and asynchronous reset.
module tb_seg_msg_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p1_place;
    logic       p2_place;
    logic       p1_fire;
    logic       p2_fire;
    logic [7:0] anode;
    logic [7:0] cathode;
    logic       frame_tick;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] frame_cat [8];

    // Expected cathodes, digit0..digit7.
    logic [7:0] exp_idle [8] = '{8'h8C, 8'hF9, 8'h89, 8'h92, 8'h83, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_p1pl [8] = '{8'h92, 8'h86, 8'hC6, 8'h88, 8'hC7, 8'h8C, 8'hF9, 8'h8C};
    logic [7:0] exp_p2fr [8] = '{8'hAB, 8'hAF, 8'hE3, 8'h87, 8'h92, 8'hFD, 8'hA4, 8'h8C};

    seg_msg_scanner #(
        .NUM_DIGITS   (8),
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (4),
        .BLINK_HALF   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p1_place   (p1_place),
        .p2_place   (p2_place),
        .p1_fire    (p1_fire),
        .p2_fire    (p2_fire),
        .anode      (anode),
        .cathode    (cathode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_tick();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) return;
        end
        compared++;
        mismatched++;
        $display("FAIL wait_tick: frame_tick=0 for 80 cycles, want 1");
    endtask

    task automatic wait_digit(input int d);
        logic [7:0] want;
        want = ~(8'h01 << d);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (anode === want) return;
        end
        compared++;
        mismatched++;
        $display("FAIL wait_digit%0d: anode=%h, want %h within 64 cycles", d, anode, want);
    endtask

    task automatic capture_frame();
        wait_tick();
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            frame_cat[d] = cathode;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        p1_place = 1'b0;
        p2_place = 1'b0;
        p1_fire  = 1'b0;
        p2_fire  = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (anode !== 8'hFF) begin
            mismatched++;
            $display("FAIL reset_anode: got %h want ff", anode);
        end
        compared++;
        if (cathode !== 8'hFF) begin
            mismatched++;
            $display("FAIL reset_cathode: got %h want ff", cathode);
        end
        compared++;
        if (frame_tick !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_tick: got %b want 0", frame_tick);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] exp_an;
            @(negedge clk);
            exp_an = ~(8'h01 << (i / 4));
            compared++;
            if (anode !== exp_an) begin
                mismatched++;
                $display("FAIL scan_anode cycle%0d: got %h want %h", i, anode, exp_an);
            end
            compared++;
            if (cathode !== exp_idle[i/4]) begin
                mismatched++;
                $display("FAIL idle_cathode cycle%0d: got %h want %h", i, cathode, exp_idle[i/4]);
            end
            compared++;
            if (frame_tick !== (i == 31)) begin
                mismatched++;
                $display("FAIL frame_tick cycle%0d: got %b want %b", i, frame_tick, (i == 31));
            end
        end
    endtask

    task automatic test_mid_frame_change();
        wait_digit(3);
        p1_place = 1'b1;
        wait_digit(4);
        compared++;
        if (cathode !== 8'h83) begin
            mismatched++;
            $display("FAIL torn_digit4: got %h want 83", cathode);
        end
        wait_digit(5);
        compared++;
        if (cathode !== 8'hFF) begin
            mismatched++;
            $display("FAIL torn_digit5: got %h want ff", cathode);
        end
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            compared++;
            if (frame_cat[d] !== exp_p1pl[d]) begin
                mismatched++;
                $display("FAIL p1place_frame1 digit%0d: got %h want %h", d, frame_cat[d], exp_p1pl[d]);
            end
        end
    endtask

    task automatic test_blink();
        // Frames 2..6 after the change: dark, lit, dark, steady, steady.
        for (int f = 2; f <= 6; f++) begin
            capture_frame();
            for (int d = 0; d < 8; d++) begin
                logic [7:0] want;
                want = (f == 2 || f == 4) ? 8'hFF : exp_p1pl[d];
                compared++;
                if (frame_cat[d] !== want) begin
                    mismatched++;
                    $display("FAIL blink_frame%0d digit%0d: got %h want %h", f, d, frame_cat[d], want);
                end
            end
        end
    endtask

    task automatic test_priority();
        p2_fire = 1'b1;
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            compared++;
            if (frame_cat[d] !== exp_p1pl[d]) begin
                mismatched++;
                $display("FAIL prio_both digit%0d: got %h want %h", d, frame_cat[d], exp_p1pl[d]);
            end
        end
        p1_place = 1'b0;
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            compared++;
            if (frame_cat[d] !== exp_p2fr[d]) begin
                mismatched++;
                $display("FAIL p2fire_frame1 digit%0d: got %h want %h", d, frame_cat[d], exp_p2fr[d]);
            end
        end
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            compared++;
            if (frame_cat[d] !== 8'hFF) begin
                mismatched++;
                $display("FAIL p2fire_frame2 digit%0d: got %h want ff", d, frame_cat[d]);
            end
        end
        wait_tick();
        wait_tick();
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            compared++;
            if (frame_cat[d] !== exp_p2fr[d]) begin
                mismatched++;
                $display("FAIL p2fire_frame5 digit%0d: got %h want %h", d, frame_cat[d], exp_p2fr[d]);
            end
        end
    endtask

    task automatic test_short_pulse();
        p2_fire = 1'b0;
        repeat (5) wait_tick();
        wait_digit(2);
        p2_fire = 1'b1;
        @(negedge clk);
        @(negedge clk);
        p2_fire = 1'b0;
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int d = 0; d < 8; d++) begin
                compared++;
                if (frame_cat[d] !== exp_idle[d]) begin
                    mismatched++;
                    $display("FAIL pulse_frame%0d digit%0d: got %h want %h", f, d, frame_cat[d], exp_idle[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        wait_digit(3);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (anode !== 8'hFF) begin
            mismatched++;
            $display("FAIL async_reset_anode: got %h want ff", anode);
        end
        compared++;
        if (cathode !== 8'hFF) begin
            mismatched++;
            $display("FAIL async_reset_cathode: got %h want ff", cathode);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_an;
            @(negedge clk);
            exp_an = ~(8'h01 << (i / 4));
            compared++;
            if (anode !== exp_an) begin
                mismatched++;
                $display("FAIL restart_anode cycle%0d: got %h want %h", i, anode, exp_an);
            end
            compared++;
            if (cathode !== exp_idle[i/4]) begin
                mismatched++;
                $display("FAIL restart_cathode cycle%0d: got %h want %h", i, cathode, exp_idle[i/4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mid_frame_change();
        test_blink();
        test_priority();
        test_short_pulse();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
